// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the RV32I fetch stage.
// Holds the fetch address and offers it to instruction memory over valid/ready.
// The next PC is chosen by priority: trap, then halt, then misaligned target,
// then taken target, then sequential. A halt at HALT_ADDR parks the fetch
// until resume or trap.
//
// state     | meaning
// ----------+-------------------------------------------
// ST_RUN    | fetching; pc offered whenever not stalled
// ST_HALTED | pc frozen at HALT_ADDR, no fetch requests
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter logic [XLEN-1:0] HALT_ADDR    = XLEN'(32'h0000_004C),
  parameter bit              HALT_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_enable,
  input  logic [XLEN-1:0] pc_target,
  input  logic            pc_src,
  input  logic            trap_req,
  input  logic            stall,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misaligned,
  output logic [XLEN-1:0] epc,
  output logic [31:0]     fetch_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [31:0]     r_fetch_count;
  logic            r_misaligned;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic [31:0]     w_fetch_count_nxt;
  logic            w_misaligned_nxt;
  logic            w_adv;
  logic            w_halt_hit;
  logic            w_target_bad;

  assign pc          = r_pc;
  assign epc         = r_epc;
  assign fetch_count = r_fetch_count;
  assign misaligned  = r_misaligned;
  assign pc_plus_4   = r_pc + XLEN'(4);
  assign fetch_valid = (r_state == ST_RUN) && !stall;
  assign halted      = (r_state == ST_HALTED);

  // An accepted fetch; fetch_valid already excludes HALTED and stalls.
  assign w_adv        = clk_enable && fetch_valid && fetch_ready;
  assign w_halt_hit   = HALT_EN && (r_pc == HALT_ADDR);
  assign w_target_bad = (pc_target[1:0] != 2'b00);

  // Register update; reset wins over clk_enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VECTOR;
      r_epc         <= '0;
      r_fetch_count <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_epc         <= w_epc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_misaligned  <= w_misaligned_nxt;
    end
  end

  // Next-state and next-PC selection; everything holds when clk_enable is low.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_epc_nxt         = r_epc;
    w_fetch_count_nxt = r_fetch_count;
    w_misaligned_nxt  = r_misaligned;
    if (clk_enable) begin
      w_misaligned_nxt = 1'b0;
      if (w_adv) begin
        w_fetch_count_nxt = r_fetch_count + 32'd1;
      end
      case (r_state)
        ST_RUN: begin
          if (trap_req) begin
            w_pc_nxt  = TRAP_VECTOR;
            w_epc_nxt = r_pc;
          end else if (w_adv && w_halt_hit) begin
            // pc stays at HALT_ADDR; pc_src is ignored on the halting fetch
            w_state_nxt = ST_HALTED;
          end else if (w_adv && pc_src && w_target_bad) begin
            w_pc_nxt         = TRAP_VECTOR;
            w_epc_nxt        = r_pc;
            w_misaligned_nxt = 1'b1;
          end else if (w_adv && pc_src) begin
            w_pc_nxt = pc_target;
          end else if (w_adv) begin
            w_pc_nxt = pc_plus_4;
          end
        end
        ST_HALTED: begin
          if (trap_req) begin
            w_pc_nxt    = TRAP_VECTOR;
            w_epc_nxt   = r_pc;
            w_state_nxt = ST_RUN;
          end else if (resume) begin
            w_pc_nxt    = pc_plus_4;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a default instance under full stimulus,
// plus a HALT_EN=0 instance and an XLEN=16 instance on the shared sequential inputs.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] tgt;
  logic        src;
  logic        trap;
  logic        stall;
  logic        resume;
  logic        ready;

  logic [31:0] pc, pp4, epc, cnt;
  logic        fv, hlt, mis;

  logic [31:0] nh_pc, nh_pp4, nh_epc, nh_cnt;
  logic        nh_fv, nh_hlt, nh_mis;

  logic [15:0] s_pc, s_pp4, s_epc;
  logic [31:0] s_cnt;
  logic        s_fv, s_hlt, s_mis;

  int n_total;
  int n_bad;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic [31:0] epc;
    logic [31:0] cnt;
    logic        mis;
    logic        hlt;
    logic        fv;
    logic [31:0] nh_pc;
    logic [15:0] s_pc;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [31:0] m_pc, m_epc, m_cnt, m_nh;
  logic [15:0] m_s;
  logic        m_halt, m_mis;

  pc_sequencer dut (
    .clk(clk), .reset_n(rst_n), .clk_enable(en), .pc_target(tgt), .pc_src(src),
    .trap_req(trap), .stall(stall), .resume(resume), .fetch_ready(ready),
    .pc(pc), .pc_plus_4(pp4), .fetch_valid(fv), .halted(hlt), .misaligned(mis),
    .epc(epc), .fetch_count(cnt)
  );

  pc_sequencer #(.HALT_EN(1'b0)) dut_nh (
    .clk(clk), .reset_n(rst_n), .clk_enable(en), .pc_target(32'h0), .pc_src(1'b0),
    .trap_req(1'b0), .stall(1'b0), .resume(1'b0), .fetch_ready(ready),
    .pc(nh_pc), .pc_plus_4(nh_pp4), .fetch_valid(nh_fv), .halted(nh_hlt),
    .misaligned(nh_mis), .epc(nh_epc), .fetch_count(nh_cnt)
  );

  pc_sequencer #(.XLEN(16), .RESET_VECTOR(16'hFFF8), .TRAP_VECTOR(16'h0100),
                 .HALT_ADDR(16'h004C), .HALT_EN(1'b0)) dut16 (
    .clk(clk), .reset_n(rst_n), .clk_enable(en), .pc_target(16'h0), .pc_src(1'b0),
    .trap_req(1'b0), .stall(1'b0), .resume(1'b0), .fetch_ready(ready),
    .pc(s_pc), .pc_plus_4(s_pp4), .fetch_valid(s_fv), .halted(s_hlt),
    .misaligned(s_mis), .epc(s_epc), .fetch_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model one clock with the currently driven inputs, push the
  // expectation, clock the DUTs, then pop and compare.
  task automatic tick();
    exp_t        e;
    exp_t        o;
    logic [31:0] npc, nepc, ncnt;
    logic        nhalt, nmis, mfv, madv;
    npc = m_pc; nepc = m_epc; ncnt = m_cnt; nhalt = m_halt; nmis = m_mis;
    if (!rst_n) begin
      npc = 32'h0; nepc = 32'h0; ncnt = 32'h0; nmis = 1'b0; nhalt = 1'b0;
      m_nh = 32'h0; m_s = 16'hFFF8;
    end else if (en) begin
      mfv  = !m_halt && !stall;
      madv = mfv && ready;
      nmis = 1'b0;
      if (madv) ncnt = m_cnt + 1;
      if (!m_halt) begin
        if (trap) begin
          nepc = m_pc; npc = 32'h100;
        end else if (madv && m_pc == 32'h4C) begin
          nhalt = 1'b1;
        end else if (madv && src && tgt[1:0] != 2'b00) begin
          nepc = m_pc; npc = 32'h100; nmis = 1'b1;
        end else if (madv && src) begin
          npc = tgt;
        end else if (madv) begin
          npc = m_pc + 32'd4;
        end
      end else begin
        if (trap) begin
          nepc = m_pc; npc = 32'h100; nhalt = 1'b0;
        end else if (resume) begin
          npc = m_pc + 32'd4; nhalt = 1'b0;
        end
      end
      if (ready) begin
        m_nh = m_nh + 32'd4;
        m_s  = m_s + 16'd4;
      end
    end
    m_pc = npc; m_epc = nepc; m_cnt = ncnt; m_halt = nhalt; m_mis = nmis;
    e.pc = m_pc; e.pp4 = m_pc + 32'd4; e.epc = m_epc; e.cnt = m_cnt;
    e.mis = m_mis; e.hlt = m_halt; e.fv = !m_halt && !stall;
    e.nh_pc = m_nh; e.s_pc = m_s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("pc", pc, o.pc);
    chk("pc_plus_4", pp4, o.pp4);
    chk("epc", epc, o.epc);
    chk("fetch_count", cnt, o.cnt);
    chk("misaligned", {31'b0, mis}, {31'b0, o.mis});
    chk("halted", {31'b0, hlt}, {31'b0, o.hlt});
    chk("fetch_valid", {31'b0, fv}, {31'b0, o.fv});
    chk("nohalt_pc", nh_pc, o.nh_pc);
    chk("x16_pc", {16'h0, s_pc}, {16'h0, o.s_pc});
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    m_pc = 0; m_epc = 0; m_cnt = 0; m_nh = 0; m_s = 16'hFFF8; m_halt = 0; m_mis = 0;
    rst_n = 1'b0; en = 1'b1; tgt = 32'h0; src = 1'b0; trap = 1'b0;
    stall = 1'b0; resume = 1'b0; ready = 1'b0;

    // reset and sequential fetch
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_fv", {31'b0, fv}, 32'h1);
    rst_n = 1'b1; ready = 1'b1;
    tick(); tick();
    chk("seq_pc", pc, 32'h8);

    // branch under backpressure
    ready = 1'b0; src = 1'b1; tgt = 32'h40;
    tick(); tick();
    chk("bp_hold_pc", pc, 32'h8);
    ready = 1'b1;
    tick();
    chk("branch_pc", pc, 32'h40);
    chk("branch_cnt", cnt, 32'h3);

    // misaligned target from 0x10
    tgt = 32'h10; tick();
    tgt = 32'h22; tick();
    chk("mis_pc", pc, 32'h100);
    chk("mis_epc", epc, 32'h10);
    chk("mis_flag", {31'b0, mis}, 32'h1);
    src = 1'b0; tick();
    chk("mis_clear", {31'b0, mis}, 32'h0);

    // run into halt, hold with junk target, resume
    src = 1'b1; tgt = 32'h40; tick();
    src = 1'b0; tick(); tick(); tick(); tick();
    chk("halt_flag", {31'b0, hlt}, 32'h1);
    chk("halt_pc", pc, 32'h4C);
    src = 1'b1; tgt = 32'h22;
    for (int i = 0; i < 10; i++) tick();
    chk("halt_hold_pc", pc, 32'h4C);
    chk("halt_fv", {31'b0, fv}, 32'h0);
    src = 1'b0; resume = 1'b1; tick();
    resume = 1'b0;
    chk("resume_pc", pc, 32'h50);
    chk("resume_halted", {31'b0, hlt}, 32'h0);

    // trap beats resume in HALTED, trap during stall
    src = 1'b1; tgt = 32'h4C; tick();
    src = 1'b0; tick();
    trap = 1'b1; resume = 1'b1; tick();
    trap = 1'b0; resume = 1'b0;
    chk("trap_h_pc", pc, 32'h100);
    chk("trap_h_epc", epc, 32'h4C);
    chk("trap_h_run", {31'b0, hlt}, 32'h0);
    stall = 1'b1; trap = 1'b1; tick();
    stall = 1'b0; trap = 1'b0;
    chk("trap_stall_pc", pc, 32'h100);

    // enable gating holds everything, including the misaligned flag
    src = 1'b1; tgt = 32'h22; tick();
    src = 1'b0; en = 1'b0;
    tick(); tick(); tick();
    chk("en_hold_mis", {31'b0, mis}, 32'h1);
    chk("en_hold_cnt", cnt, 32'd14);
    rst_n = 1'b0; tick();
    chk("rst_noen_pc", pc, 32'h0);
    rst_n = 1'b1; en = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      en     = ($urandom_range(0, 7) != 0);
      ready  = $urandom_range(0, 1);
      stall  = ($urandom_range(0, 3) == 0);
      src    = $urandom_range(0, 1);
      tgt    = 32'($urandom_range(0, 40)) * 32'd4 + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
      trap   = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 3) == 0);
      rst_n  = ($urandom_range(0, 60) != 0);
      tick();
    end

    // reset under stall, then XLEN=16 wrap and HALT_EN=0 run-through
    rst_n = 1'b0; en = 1'b1; stall = 1'b1; src = 1'b0; trap = 1'b0; resume = 1'b0; ready = 1'b1;
    tick();
    rst_n = 1'b1; stall = 1'b0;
    tick();
    chk("x16_fffc", {16'h0, s_pc}, 32'hFFFC);
    chk("x16_wrap_p4", {16'h0, s_pp4}, 32'h0);
    tick();
    chk("x16_zero", {16'h0, s_pc}, 32'h0);
    for (int i = 0; i < 18; i++) tick();
    chk("long_halted", {31'b0, hlt}, 32'h1);
    chk("nohalt_pass", nh_pc, 32'h50);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("rst_from_halt", {31'b0, hlt}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter and fetch sequencer for the RISC-V 32I core, the next generation of the single-cycle PC register. It holds the current fetch address and presents it to instruction memory through a valid/ready handshake. It selects the next PC by priority from trap, branch/jump target and sequential increment, traps on misaligned control-flow targets, and halts at a configurable address until resumed. It sits at the head of the fetch stage, driven by the control unit's pc_src and by external stall, trap and resume requests.

## Interface
Parameters:
- XLEN, 32, address/PC width in bits (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a trap or misaligned target; must be 4-byte aligned
- HALT_ADDR, 32'h0000_004C, PC value at which the sequencer halts
- HALT_EN, 1, 1 enables halting at HALT_ADDR; 0 disables it

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset_n  in  1  synchronous, active-low reset
- clk_enable  in  1  global enable; when 0, all registers hold (reset excepted)
- pc_target  in  XLEN  branch/jump target
- pc_src  in  1  1 selects pc_target as the next PC
- trap_req  in  1  external trap request
- stall  in  1  pipeline stall; blocks PC advance
- resume  in  1  leave the HALTED state
- fetch_ready  in  1  instruction memory accepts the current PC
- pc  out  XLEN  current fetch address (registered)
- pc_plus_4  out  XLEN  pc + 4, combinational, modulo 2^XLEN
- fetch_valid  out  1  pc is a valid fetch request
- halted  out  1  sequencer is in HALTED
- misaligned  out  1  one-cycle flag: misaligned target trapped
- epc  out  XLEN  PC of the instruction that trapped
- fetch_count  out  32  number of accepted fetches; wraps at 2^32

## Operation
- Reset (reset_n=0 at posedge) takes effect regardless of clk_enable. It sets:
  - pc=RESET_VECTOR, state=RUN
  - epc=0, fetch_count=0, misaligned=0
- States:
  - RUN: fetching.
  - HALTED: pc frozen.
- Output decode:
  - fetch_valid = (state==RUN) && !stall.
  - halted = (state==HALTED).
- Advance event (adv) = clk_enable && fetch_valid && fetch_ready.
- In RUN, next PC is chosen by priority:
  1. trap_req (acts even when adv=0, provided clk_enable=1): pc←TRAP_VECTOR, epc←pc.
  2. adv && pc_src && pc_target[1:0]≠0: pc←TRAP_VECTOR, epc←pc, misaligned←1.
  3. adv && pc_src: pc←pc_target.
  4. adv: pc←pc_plus_4.
  5. Otherwise pc holds.
- Halt condition: adv && HALT_EN && pc==HALT_ADDR && !trap_req. The state goes to HALTED and pc holds HALT_ADDR; pc_src/pc_target are ignored in this cycle.
- In HALTED (with clk_enable=1):
  - trap_req: pc←TRAP_VECTOR, epc←pc, state←RUN.
  - Otherwise resume: pc←pc_plus_4, state←RUN.
  - Otherwise everything holds.
  - trap_req beats resume in the same cycle.
- fetch_count increments by 1 on every adv, including the halting fetch and fetches that trap.
- misaligned is 1 only in the enabled cycle following detection and clears on the next enabled cycle. With clk_enable=0 it holds, like all other registers.
- stall=1 suppresses fetch_valid and adv. trap_req is still honoured during a stall.
- pc_plus_4 wraps: pc=2^XLEN−4 gives pc_plus_4=0.

## Timing
- pc latency: updates on the posedge that samples adv/trap_req and is visible the cycle after.
- Reset release: fetch_valid=1 in the first cycle after reset_n rises, provided stall=0.
- Handshake: fetch_valid does not depend on fetch_ready. pc is stable while fetch_valid=1 and fetch_ready=0, except when trap_req redirects it.
- Halting: halted rises the cycle after the accepted fetch at HALT_ADDR. fetch_valid is 0 from that cycle on.
- Resume: fetch_valid returns one cycle after resume is sampled, with pc=HALT_ADDR+4.
- Reset mid-operation: a reset in any state, including HALTED or during a stall, returns the block to reset values next cycle.

## Test plan
- Reset/sequential: reset_n=0 for 2 cycles, then fetch_ready=1 for 4 cycles → pc goes 0x0, 0x4, 0x8, 0xC, 0x10; fetch_count=4.
- Branch and backpressure: at pc=0x8, pc_src=1 and pc_target=0x40 with fetch_ready=0 for 2 cycles, then 1 → pc stays 0x8 for 2 cycles, then becomes 0x40; fetch_count increments once.
- Misaligned target: at pc=0x10, pc_src=1, pc_target=0x22, adv → pc=0x100, epc=0x10, misaligned=1 for exactly one cycle.
- Halt/resume: run from 0x40 to 0x4C with fetch_ready=1 → halted=1, pc holds 0x4C for 10 cycles, fetch_valid=0. Then resume=1 → pc=0x50, halted=0. Repeat with HALT_EN=0 → no halt, pc passes 0x50.
- Trap priority: in HALTED, assert trap_req and resume together → pc=0x100, epc=0x4C, state RUN. In RUN with stall=1, trap_req → pc=0x100.
- Enable and reset: clk_enable=0 for 3 cycles with fetch_ready=1 → pc, fetch_count and misaligned all hold. reset_n=0 with clk_enable=0 → pc=RESET_VECTOR next cycle. With XLEN=16 at pc=0xFFFC, adv → pc=0x0000.
